acumulador_produtos: RTL

ACUMULADOR_PRODUTOS -- requirements
Module: acumulador_produtos

---
 rtl/acumulador_produtos_fd.sv | 59 +++++
 rtl/acumulador_produtos_uc.sv | 123 ++++++++++++
 rtl/acumulador_produtos.sv | 84 ++++++++
 3 files changed

// File: rtl/acumulador_produtos_fd.sv
`default_nettype none
// ============================================================================
// Module   : acumulador_produtos_fd
// Purpose  : Datapath of the product accumulator: accumulator register, the
//            single adder and the presented-sum register.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            P_in          - unsigned product, zero-extended to ACC_W
//            acc_en        - acc <= acc + P_in
//            acc_ld_first  - acc <= P_in
//            acc_clr       - acc <= 0 (highest priority)
//            sum_ld        - sum_out <= acc + P_in
//            sum_out       - presented group sum
// Revision : 1.0 - initial release
// ============================================================================
module acumulador_produtos_fd #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  P_in,
    input  logic             acc_en,
    input  logic             acc_ld_first,
    input  logic             acc_clr,
    input  logic             sum_ld,
    output logic [ACC_W-1:0] sum_out
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_sum;
    logic [ACC_W-1:0] w_p_ext;
    logic [ACC_W-1:0] w_add;

    assign w_p_ext = ACC_W'(P_in);
    // Guard bits make this sum exact for up to 2^GUARD products.
    assign w_add   = r_acc + w_p_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_sum <= '0;
        end else begin
            if (sum_ld) begin
                r_sum <= w_add;
            end
            if (acc_clr) begin
                r_acc <= '0;
            end else if (acc_ld_first) begin
                r_acc <= w_p_ext;
            end else if (acc_en) begin
                r_acc <= w_add;
            end
        end
    end

    assign sum_out = r_sum;

endmodule
`default_nettype wire

// File: rtl/acumulador_produtos_uc.sv
`default_nettype none
// ============================================================================
// Module   : acumulador_produtos_uc
// Purpose  : Control unit of the product accumulator. Holds the ACC/HOLD
//            state, the product counter of the current group and the sticky
//            lost flag, and drives the datapath enables.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            clear            - group abort (acc, cnt, state, lost)
//            mul_done         - product valid this cycle
//            out_ack          - consumer accepts the presented sum
//            acc_en           - acc <= acc + product
//            acc_ld_first     - acc <= product (first product of a group)
//            acc_clr          - acc <= 0
//            sum_ld           - sum register <= acc + product
//            out_valid, stall - high while a result is presented (HOLD)
//            lost             - sticky: a product arrived in HOLD unaccepted
// Revision : 1.0 - initial release
// ============================================================================
module acumulador_produtos_uc #(
    parameter int N     = 4,
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic mul_done,
    input  logic out_ack,
    output logic acc_en,
    output logic acc_ld_first,
    output logic acc_clr,
    output logic sum_ld,
    output logic out_valid,
    output logic stall,
    output logic lost
);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_next_cnt;
    logic               r_lost;
    logic               w_next_lost;
    logic               w_last;

    // The current product closes the group when N-1 products are already in.
    assign w_last = (r_cnt == CNT_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
            r_cnt   <= '0;
            r_lost  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_lost  <= w_next_lost;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_lost  = r_lost;
        acc_en       = 1'b0;
        acc_ld_first = 1'b0;
        acc_clr      = 1'b0;
        sum_ld       = 1'b0;

        if (clear) begin
            // Abort wins over any product or acknowledge in the same cycle.
            w_next_state = ST_ACC;
            w_next_cnt   = '0;
            w_next_lost  = 1'b0;
            acc_clr      = 1'b1;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (mul_done) begin
                        if (w_last) begin
                            // Sum register captures acc + product directly,
                            // so the result appears one cycle after the
                            // last product while acc restarts from zero.
                            sum_ld       = 1'b1;
                            acc_clr      = 1'b1;
                            w_next_cnt   = '0;
                            w_next_state = ST_HOLD;
                        end else begin
                            acc_en     = 1'b1;
                            w_next_cnt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ack) begin
                        w_next_state = ST_ACC;
                        if (mul_done) begin
                            // acc is already zero here; load starts the
                            // next group with this product.
                            acc_ld_first = 1'b1;
                            w_next_cnt   = CNT_W'(1);
                        end
                    end else if (mul_done) begin
                        w_next_lost = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_ACC;
                end
            endcase
        end
    end

    assign out_valid = (r_state == ST_HOLD);
    assign stall     = (r_state == ST_HOLD);
    assign lost      = r_lost;

endmodule
`default_nettype wire

// File: rtl/acumulador_produtos.sv
`default_nettype none
// ============================================================================
// Module   : acumulador_produtos
// Purpose  : Sums groups of N unsigned products from an upstream multiplier
//            and presents each group sum with a valid/ack handshake.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            clear      - abort current group, clears lost
//            mul_done   - one-cycle pulse, P_in valid
//            P_in       - 2*WIDTH-bit unsigned product
//            out_ack    - consumer accepts sum_out (only while out_valid)
//            sum_out    - group sum, ACC_W = 2*WIDTH+GUARD bits
//            out_valid  - sum_out valid, held until acknowledged
//            stall      - upstream must not start a new multiply
//            lost       - sticky, a product was dropped while holding
// Revision : 1.0 - initial release
// ============================================================================
module acumulador_produtos #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int GUARD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       mul_done,
    input  logic [2*WIDTH-1:0]         P_in,
    input  logic                       out_ack,
    output logic [2*WIDTH+GUARD-1:0]   sum_out,
    output logic                       out_valid,
    output logic                       stall,
    output logic                       lost
);

    localparam int ACC_W = 2 * WIDTH + GUARD;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (N < 2) begin : g_bad_n_min
            $error("acumulador_produtos: N must be at least 2");
        end
        if (N > (2 ** GUARD)) begin : g_bad_n_guard
            $error("acumulador_produtos: N exceeds 2^GUARD, sum could overflow");
        end
    endgenerate

    logic w_acc_en;
    logic w_acc_ld_first;
    logic w_acc_clr;
    logic w_sum_ld;

    acumulador_produtos_uc #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_uc (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .mul_done     (mul_done),
        .out_ack      (out_ack),
        .acc_en       (w_acc_en),
        .acc_ld_first (w_acc_ld_first),
        .acc_clr      (w_acc_clr),
        .sum_ld       (w_sum_ld),
        .out_valid    (out_valid),
        .stall        (stall),
        .lost         (lost)
    );

    acumulador_produtos_fd #(
        .IN_W  (2 * WIDTH),
        .ACC_W (ACC_W)
    ) u_fd (
        .clk          (clk),
        .rst          (rst),
        .P_in         (P_in),
        .acc_en       (w_acc_en),
        .acc_ld_first (w_acc_ld_first),
        .acc_clr      (w_acc_clr),
        .sum_ld       (w_sum_ld),
        .sum_out      (sum_out)
    );

endmodule
`default_nettype wire
